// File: rtl/hazard_if.sv
// ============================================================================
// Module   : hazard_if
// Brief    : Decode / register-read / writeback / drain signal bundle for the
//            register-write hazard scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_if #(
  parameter int NREG = 16
);
  // decode stage
  logic            id_valid;
  logic [3:0]      id_rs;
  logic [3:0]      id_rt;
  logic            id_rs_used;
  logic            id_rt_used;
  logic [3:0]      id_rd;
  logic            id_rd_en;
  // register-read stage
  logic            rr_valid;
  logic [3:0]      rr_rd;
  logic            rr_rd_en;
  // execute control
  logic            exec_stall;
  logic            exec_flush;
  // writeback
  logic            wb_valid;
  logic [3:0]      wb_rd;
  logic            wb_rd_en;
  // drain handshake
  logic            drain_req;
  // scoreboard results
  logic            o_stall;
  logic            o_idle;
  logic [NREG-1:0] o_pending;
  logic            o_err;

  // pipeline side: drives stage state, observes stall/idle/status
  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_rd_en,
    output rr_valid, rr_rd, rr_rd_en, exec_stall, exec_flush,
    output wb_valid, wb_rd, wb_rd_en, drain_req,
    input  o_stall, o_idle, o_pending, o_err
  );

  // scoreboard side
  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_rd_en,
    input  rr_valid, rr_rd, rr_rd_en, exec_stall, exec_flush,
    input  wb_valid, wb_rd, wb_rd_en, drain_req,
    output o_stall, o_idle, o_pending, o_err
  );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Per-register in-flight write counters producing the decode stall
//            for RAW and counter-saturation hazards, plus a drain/idle
//            handshake for pipeline-wide operations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int NREG  = 16,
  parameter int CNT_W = 2
) (
  input  wire logic i_clk,
  input  wire logic i_reset,
  hazard_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt     [NREG];
  logic [NREG-1:0]  r_pending;
  logic             r_idle;
  logic             r_err;

  logic [CNT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  w_nz;
  logic [NREG-1:0]  w_nz_nxt;
  logic             w_rr_wr;
  logic             w_inc;
  logic             w_dec;
  logic             w_underflow;
  logic             w_raw_rs;
  logic             w_raw_rt;
  logic             w_sat;
  logic             w_drain_hold;

  // A writing instruction sits in register read; it counts only once it issues
  assign w_rr_wr     = bus.rr_valid && bus.rr_rd_en;
  assign w_inc       = w_rr_wr && !bus.exec_stall && !bus.exec_flush;
  assign w_dec       = bus.wb_valid && bus.wb_rd_en;
  assign w_underflow = w_dec && (r_cnt[bus.wb_rd] == '0);

  // Next-state counters: matched inc/dec on one index cancel out
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc && (bus.rr_rd == 4'(i)) && !(w_dec && (bus.wb_rd == 4'(i)))) begin
        if (r_cnt[i] != c_CNT_MAX) w_cnt_nxt[i] = r_cnt[i] + c_CNT_ONE;
      end else if (w_dec && (bus.wb_rd == 4'(i)) && !(w_inc && (bus.rr_rd == 4'(i)))) begin
        if (r_cnt[i] != '0) w_cnt_nxt[i] = r_cnt[i] - c_CNT_ONE;
      end
      w_nz[i]     = (r_cnt[i] != '0);
      w_nz_nxt[i] = (w_cnt_nxt[i] != '0);
    end
  end

  // Hazards; a same-cycle writeback does not clear RAW (regfile write lands at the edge)
  assign w_raw_rs = bus.id_rs_used &&
                    ((r_cnt[bus.id_rs] != '0) || (w_rr_wr && (bus.rr_rd == bus.id_rs)));
  assign w_raw_rt = bus.id_rt_used &&
                    ((r_cnt[bus.id_rt] != '0) || (w_rr_wr && (bus.rr_rd == bus.id_rt)));
  assign w_sat    = bus.id_rd_en && (r_cnt[bus.id_rd] == c_CNT_MAX) &&
                    !(w_dec && (bus.wb_rd == bus.id_rd));

  assign w_drain_hold = (r_state == S_DRAIN);

  assign bus.o_stall   = bus.exec_stall ||
                         (bus.id_valid && (w_raw_rs || w_raw_rt || w_sat)) ||
                         w_drain_hold;
  assign bus.o_idle    = r_idle;
  assign bus.o_pending = r_pending;
  assign bus.o_err     = r_err;

  // Counter state, registered status flags and sticky underflow error
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_pending <= '0;
      r_idle    <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_pending <= w_nz_nxt;
      r_idle    <= ~|w_nz_nxt && !w_rr_wr;
      r_err     <= r_err || w_underflow;
    end
  end

  // Drain FSM: hold decode until the pipeline is empty and the requester lets go
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.drain_req) r_state <= S_DRAIN;
        S_DRAIN: if (~|w_nz && !w_rr_wr && !bus.drain_req) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed self-checking bench for hazard_scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  logic i_clk;
  logic i_reset;
  int   n_pass;
  int   n_total;

  hazard_if #(.NREG(16)) bus ();

  hazard_scoreboard #(.NREG(16), .CNT_W(2)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rs_used = 0;
    bus.id_rt_used = 0; bus.id_rd = 0; bus.id_rd_en = 0;
    bus.rr_valid = 0; bus.rr_rd = 0; bus.rr_rd_en = 0;
    bus.exec_stall = 0; bus.exec_flush = 0;
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_rd_en = 0;
    bus.drain_req = 0;
  endtask

  task automatic issue(input logic [3:0] rd);
    bus.rr_valid = 1; bus.rr_rd = rd; bus.rr_rd_en = 1;
  endtask

  task automatic retire(input logic [3:0] rd);
    bus.wb_valid = 1; bus.wb_rd = rd; bus.wb_rd_en = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1;
    tick(); tick();
    i_reset = 0;
    #1;
    n_total++; if (bus.o_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.o_stall); else n_pass++;
    n_total++; if (bus.o_idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", bus.o_idle); else n_pass++;
    n_total++; if (bus.o_pending !== 16'h0000) $display("FAIL reset_pending got=%h exp=0000", bus.o_pending); else n_pass++;
    n_total++; if (bus.o_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.o_err); else n_pass++;
  endtask

  task automatic test_raw();
    clear_inputs();
    issue(4'd3);
    bus.id_valid = 1; bus.id_rs = 4'd3; bus.id_rs_used = 1;
    #1;
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL raw_rr_match got=%b exp=1", bus.o_stall); else n_pass++;
    tick();
    bus.rr_valid = 0; bus.rr_rd_en = 0;
    #1;
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL raw_counted got=%b exp=1", bus.o_stall); else n_pass++;
    n_total++; if (bus.o_pending !== 16'h0008) $display("FAIL raw_pending got=%h exp=0008", bus.o_pending); else n_pass++;
    n_total++; if (bus.o_idle !== 1'b0) $display("FAIL raw_idle got=%b exp=0", bus.o_idle); else n_pass++;
    retire(4'd3);
    #1;
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL raw_same_cycle_wb got=%b exp=1", bus.o_stall); else n_pass++;
    tick();
    bus.wb_valid = 0; bus.wb_rd_en = 0;
    #1;
    n_total++; if (bus.o_stall !== 1'b0) $display("FAIL raw_released got=%b exp=0", bus.o_stall); else n_pass++;
    n_total++; if (bus.o_pending !== 16'h0000) $display("FAIL raw_pending_clr got=%h exp=0000", bus.o_pending); else n_pass++;
    n_total++; if (bus.o_idle !== 1'b1) $display("FAIL raw_idle_back got=%b exp=1", bus.o_idle); else n_pass++;
    // rt path also flags a hazard against an in-register-read producer
    bus.id_rs_used = 0; bus.id_rt = 4'd11; bus.id_rt_used = 1;
    issue(4'd11);
    bus.exec_stall = 1;
    #1;
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL rt_exec_stall got=%b exp=1", bus.o_stall); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_total++; if (bus.o_pending !== 16'h0000) $display("FAIL exec_stall_blocks_inc got=%h exp=0000", bus.o_pending); else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      issue(4'd5);
      tick();
    end
    clear_inputs();
    #1;
    n_total++; if (bus.o_pending !== 16'h0020) $display("FAIL sat_pending got=%h exp=0020", bus.o_pending); else n_pass++;
    bus.id_valid = 1; bus.id_rd = 4'd5; bus.id_rd_en = 1;
    #1;
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL sat_stall got=%b exp=1", bus.o_stall); else n_pass++;
    retire(4'd5);
    #1;
    n_total++; if (bus.o_stall !== 1'b0) $display("FAIL sat_wb_release got=%b exp=0", bus.o_stall); else n_pass++;
    tick();
    bus.wb_valid = 0; bus.wb_rd_en = 0;
    #1;
    n_total++; if (bus.o_stall !== 1'b0) $display("FAIL sat_below_max got=%b exp=0", bus.o_stall); else n_pass++;
    clear_inputs();
    retire(4'd5);
    tick();
    n_total++; if (bus.o_pending !== 16'h0020) $display("FAIL sat_drain_one got=%h exp=0020", bus.o_pending); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_total++; if (bus.o_pending !== 16'h0000) $display("FAIL sat_drained got=%h exp=0000", bus.o_pending); else n_pass++;
    n_total++; if (bus.o_err !== 1'b0) $display("FAIL sat_no_err got=%b exp=0", bus.o_err); else n_pass++;
  endtask

  task automatic test_same_index();
    clear_inputs();
    issue(4'd7);
    tick();
    retire(4'd7);
    tick();
    clear_inputs();
    #1;
    n_total++; if (bus.o_pending !== 16'h0080) $display("FAIL same_idx_pending got=%h exp=0080", bus.o_pending); else n_pass++;
    retire(4'd7);
    tick();
    clear_inputs();
    #1;
    n_total++; if (bus.o_pending !== 16'h0000) $display("FAIL same_idx_count1 got=%h exp=0000", bus.o_pending); else n_pass++;
    n_total++; if (bus.o_err !== 1'b0) $display("FAIL same_idx_err got=%b exp=0", bus.o_err); else n_pass++;
  endtask

  task automatic test_flush();
    clear_inputs();
    issue(4'd2);
    tick();
    clear_inputs();
    issue(4'd9);
    bus.exec_flush = 1;
    retire(4'd2);
    tick();
    clear_inputs();
    #1;
    n_total++; if (bus.o_pending !== 16'h0000) $display("FAIL flush_pending got=%h exp=0000", bus.o_pending); else n_pass++;
    n_total++; if (bus.o_err !== 1'b0) $display("FAIL flush_err got=%b exp=0", bus.o_err); else n_pass++;
    tick();
    n_total++; if (bus.o_idle !== 1'b1) $display("FAIL flush_idle got=%b exp=1", bus.o_idle); else n_pass++;
  endtask

  task automatic test_underflow();
    clear_inputs();
    retire(4'd4);
    tick();
    clear_inputs();
    #1;
    n_total++; if (bus.o_err !== 1'b1) $display("FAIL underflow_err got=%b exp=1", bus.o_err); else n_pass++;
    n_total++; if (bus.o_pending !== 16'h0000) $display("FAIL underflow_cnt got=%h exp=0000", bus.o_pending); else n_pass++;
    tick(); tick();
    n_total++; if (bus.o_err !== 1'b1) $display("FAIL underflow_sticky got=%b exp=1", bus.o_err); else n_pass++;
  endtask

  task automatic test_drain();
    clear_inputs();
    issue(4'd1);
    tick();
    clear_inputs();
    bus.drain_req = 1;
    #1;
    n_total++; if (bus.o_stall !== 1'b0) $display("FAIL drain_req_cycle got=%b exp=0", bus.o_stall); else n_pass++;
    tick();
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL drain_hold got=%b exp=1", bus.o_stall); else n_pass++;
    n_total++; if (bus.o_idle !== 1'b0) $display("FAIL drain_not_idle got=%b exp=0", bus.o_idle); else n_pass++;
    tick();
    retire(4'd1);
    tick();
    bus.wb_valid = 0; bus.wb_rd_en = 0;
    #1;
    n_total++; if (bus.o_idle !== 1'b1) $display("FAIL drain_idle got=%b exp=1", bus.o_idle); else n_pass++;
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL drain_held_idle got=%b exp=1", bus.o_stall); else n_pass++;
    tick();
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL drain_held_req got=%b exp=1", bus.o_stall); else n_pass++;
    bus.drain_req = 0;
    #1;
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL drain_release_cycle got=%b exp=1", bus.o_stall); else n_pass++;
    tick();
    n_total++; if (bus.o_stall !== 1'b0) $display("FAIL drain_resume got=%b exp=0", bus.o_stall); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    clear_inputs();
    bus.drain_req = 1;
    tick(); tick();
    n_total++; if (bus.o_stall !== 1'b1) $display("FAIL mid_drain_hold got=%b exp=1", bus.o_stall); else n_pass++;
    bus.drain_req = 0;
    i_reset = 1;
    tick();
    i_reset = 0;
    #1;
    n_total++; if (bus.o_stall !== 1'b0) $display("FAIL mid_drain_reset got=%b exp=0", bus.o_stall); else n_pass++;
    n_total++; if (bus.o_err !== 1'b0) $display("FAIL reset_clears_err got=%b exp=0", bus.o_err); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    i_reset = 1;
    test_reset();
    test_raw();
    test_saturation();
    test_same_index();
    test_flush();
    test_underflow();
    test_drain();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
